// File: rtl/tcam_serial_driver_if.sv
// Command, TCAM serial/status and response signals of tcam_serial_driver.
// The slave modport is the driver's view; master is the surrounding environment.
interface tcam_serial_driver_if #(
    parameter int KWID    = 128,
    parameter int IDWID   = 16,
    parameter int MASKWID = 18
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_op;
    logic [KWID-1:0]    cmd_key;
    logic [IDWID-1:0]   cmd_id;
    logic [MASKWID-1:0] cmd_maskid;
    logic [IDWID-1:0]   cmd_priority;

    logic               key;
    logic               setting_id;
    logic               setting_maskid;
    logic               setting_priority;
    logic               search;
    logic               setting;

    logic [IDWID-1:0]   ruleid;
    logic               search_complete;
    logic               setting_complete;
    logic               mismatch;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_op;
    logic [IDWID-1:0]   rsp_ruleid;
    logic               rsp_mismatch;
    logic               rsp_timeout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_id, cmd_maskid, cmd_priority,
        input  ruleid, search_complete, setting_complete, mismatch, rsp_ready,
        output cmd_ready, key, setting_id, setting_maskid, setting_priority,
        output search, setting,
        output rsp_valid, rsp_op, rsp_ruleid, rsp_mismatch, rsp_timeout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_id, cmd_maskid, cmd_priority,
        output ruleid, search_complete, setting_complete, mismatch, rsp_ready,
        input  cmd_ready, key, setting_id, setting_maskid, setting_priority,
        input  search, setting,
        input  rsp_valid, rsp_op, rsp_ruleid, rsp_mismatch, rsp_timeout
    );
endinterface

// File: rtl/tcam_serial_driver.sv
// Serialises a search/setting command into a TCAM's serial-to-parallel registers,
// strobes the operation and returns the completion (or a timeout) as a response.
module tcam_serial_driver #(
    parameter int KWID    = 128,
    parameter int IDWID   = 16,
    parameter int MASKWID = 18,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tcam_serial_driver_if.slave bus
);
    localparam int CNTW  = (KWID > 1) ? $clog2(KWID) : 1;
    localparam int WCNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0]  LastBit  = CNTW'(KWID - 1);
    localparam logic [WCNTW-1:0] LastWait = WCNTW'(TIMEOUT - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_STROBE, ST_WAIT, ST_RESP} state_e;

    state_e           state_q, state_d;
    logic             readyEn_q;
    logic             op_q;
    logic [KWID-1:0]  keySr_q, idSr_q, maskSr_q, prioSr_q;
    logic [CNTW-1:0]  bitCnt_q;
    logic [WCNTW-1:0] waitCnt_q;
    logic [IDWID-1:0] rspRuleId_q;
    logic             rspMismatch_q;
    logic             rspTimeout_q;

    logic accept;
    logic done;
    logic lastWait;

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign done     = op_q ? bus.setting_complete : bus.search_complete;
    assign lastWait = (waitCnt_q == LastWait);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SHIFT;
            ST_SHIFT:  if (bitCnt_q == LastBit) state_d = ST_STROBE;
            ST_STROBE: state_d = ST_WAIT;
            ST_WAIT:   if (done || lastWait) state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // readyEn_q keeps CMD_READY low during reset and until the first clock after it.
    always_comb begin
        bus.cmd_ready        = readyEn_q && (state_q == ST_IDLE);
        bus.key              = 1'b0;
        bus.setting_id       = 1'b0;
        bus.setting_maskid   = 1'b0;
        bus.setting_priority = 1'b0;
        if (state_q == ST_SHIFT) begin
            bus.key              = keySr_q[KWID-1];
            bus.setting_id       = idSr_q[KWID-1];
            bus.setting_maskid   = maskSr_q[KWID-1];
            bus.setting_priority = prioSr_q[KWID-1];
        end
        bus.search       = (state_q == ST_STROBE) && !op_q;
        bus.setting      = (state_q == ST_STROBE) && op_q;
        bus.rsp_valid    = (state_q == ST_RESP);
        bus.rsp_op       = op_q;
        bus.rsp_ruleid   = rspRuleId_q;
        bus.rsp_mismatch = rspMismatch_q;
        bus.rsp_timeout  = rspTimeout_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            readyEn_q     <= 1'b0;
            op_q          <= 1'b0;
            keySr_q       <= '0;
            idSr_q        <= '0;
            maskSr_q      <= '0;
            prioSr_q      <= '0;
            bitCnt_q      <= '0;
            waitCnt_q     <= '0;
            rspRuleId_q   <= '0;
            rspMismatch_q <= 1'b0;
            rspTimeout_q  <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= bus.cmd_op;
                        keySr_q  <= bus.cmd_key;
                        idSr_q   <= KWID'(bus.cmd_id);
                        maskSr_q <= KWID'(bus.cmd_maskid);
                        prioSr_q <= KWID'(bus.cmd_priority);
                        bitCnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    keySr_q  <= {keySr_q[KWID-2:0], 1'b0};
                    idSr_q   <= {idSr_q[KWID-2:0], 1'b0};
                    maskSr_q <= {maskSr_q[KWID-2:0], 1'b0};
                    prioSr_q <= {prioSr_q[KWID-2:0], 1'b0};
                    bitCnt_q <= bitCnt_q + CNTW'(1);
                end
                ST_STROBE: begin
                    waitCnt_q <= '0;
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins over the final timeout cycle.
                    if (done) begin
                        rspRuleId_q   <= op_q ? '0 : bus.ruleid;
                        rspMismatch_q <= op_q ? 1'b0 : bus.mismatch;
                        rspTimeout_q  <= 1'b0;
                    end else if (lastWait) begin
                        rspRuleId_q   <= '0;
                        rspMismatch_q <= !op_q;
                        rspTimeout_q  <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_q + WCNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tcam_serial_driver.sv
// Randomised self-checking bench for tcam_serial_driver: serial receivers, strobes,
// response values and latency are compared against a behavioural model.
module tb_tcam_serial_driver;
    localparam int KWID    = 128;
    localparam int IDWID   = 16;
    localparam int MASKWID = 18;
    localparam int TIMEOUT = 16;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   compareCount = 0;
    int   failCount    = 0;

    logic [KWID-1:0]    rxKey  = '0;
    logic [IDWID-1:0]   rxId   = '0;
    logic [MASKWID-1:0] rxMask = '0;
    logic [IDWID-1:0]   rxPrio = '0;

    tcam_serial_driver_if #(.KWID(KWID), .IDWID(IDWID), .MASKWID(MASKWID)) bus ();

    tcam_serial_driver #(
        .KWID(KWID), .IDWID(IDWID), .MASKWID(MASKWID), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // TCAM-side serial-to-parallel receivers: shift left, new bit enters at the LSB.
    always @(posedge clk) begin
        rxKey  <= {rxKey[KWID-2:0], bus.key};
        rxId   <= {rxId[IDWID-2:0], bus.setting_id};
        rxMask <= {rxMask[MASKWID-2:0], bus.setting_maskid};
        rxPrio <= {rxPrio[IDWID-2:0], bus.setting_priority};
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [KWID-1:0] observed,
                               input logic [KWID-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Returns {timeout, mismatch, ruleid}; compCycle 0 means the TCAM never completes.
    function automatic logic [IDWID+1:0] modelRsp(input logic op, input int compCycle,
                                                  input logic [IDWID-1:0] ruleid, input logic mism);
        bit doneInTime;
        doneInTime = (compCycle >= 1) && (compCycle <= TIMEOUT);
        if (op) return {!doneInTime, 1'b0, {IDWID{1'b0}}};
        if (doneInTime) return {1'b0, mism, ruleid};
        return {1'b1, 1'b1, {IDWID{1'b0}}};
    endfunction

    task automatic randomCmdFields();
        bus.cmd_op       = 1'($urandom_range(0, 1));
        bus.cmd_key      = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.cmd_id       = IDWID'($urandom());
        bus.cmd_maskid   = MASKWID'($urandom());
        bus.cmd_priority = IDWID'($urandom());
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, KWID'({bus.cmd_ready, bus.key, bus.setting_id, bus.setting_maskid,
                                bus.setting_priority, bus.search, bus.setting, bus.rsp_valid,
                                bus.rsp_op, bus.rsp_ruleid, bus.rsp_mismatch, bus.rsp_timeout}),
                    '0);
    endtask

    // Called at a negedge; returns at the negedge right after the acceptance edge.
    task automatic acceptCommand(input logic op, input logic [KWID-1:0] key,
                                 input logic [IDWID-1:0] id, input logic [MASKWID-1:0] mask,
                                 input logic [IDWID-1:0] prio, output bit ok);
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_key      = key;
        bus.cmd_id       = id;
        bus.cmd_maskid   = mask;
        bus.cmd_priority = prio;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("cmd_accept", KWID'(ok), KWID'(1));
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        randomCmdFields();
    endtask

    task automatic applyStimulus(input logic op, input logic [KWID-1:0] key,
                                 input logic [IDWID-1:0] id, input logic [MASKWID-1:0] mask,
                                 input logic [IDWID-1:0] prio, input int compCycle,
                                 input logic [IDWID-1:0] ruleid, input logic mism,
                                 input bit wrongPulse, input int holdCycles);
        bit ok;
        int strobeK, rspK, nSearch, nSetting, j, expLat;
        logic [IDWID+1:0] exp;
        exp    = modelRsp(op, compCycle, ruleid, mism);
        expLat = KWID + 1 + (exp[IDWID+1] && !(compCycle >= 1 && compCycle <= TIMEOUT)
                             ? TIMEOUT : compCycle);
        acceptCommand(op, key, id, mask, prio, ok);
        if (!ok) return;
        strobeK  = -1;
        rspK     = -1;
        nSearch  = 0;
        nSetting = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.search || bus.setting) begin
                nSearch  += int'(bus.search);
                nSetting += int'(bus.setting);
                if (strobeK < 0) begin
                    strobeK = k;
                    checkOutput("rx_key", rxKey, key);
                    checkOutput("rx_id", KWID'(rxId), KWID'(id));
                    checkOutput("rx_maskid", KWID'(rxMask), KWID'(mask));
                    checkOutput("rx_priority", KWID'(rxPrio), KWID'(prio));
                end
            end
            if (bus.rsp_valid) begin
                rspK = k;
                break;
            end
            bus.search_complete  = 1'b0;
            bus.setting_complete = 1'b0;
            bus.ruleid           = IDWID'($urandom());
            bus.mismatch         = 1'($urandom_range(0, 1));
            randomCmdFields();
            if (strobeK >= 0) begin
                j = k - strobeK;
                if (wrongPulse && (j == 1 || j == 2)) begin
                    if (op) bus.search_complete = 1'b1;
                    else    bus.setting_complete = 1'b1;
                end
                if (j >= 1 && j == compCycle) begin
                    if (op) bus.setting_complete = 1'b1;
                    else    bus.search_complete = 1'b1;
                    bus.ruleid   = ruleid;
                    bus.mismatch = mism;
                end
            end
            @(negedge clk);
        end
        bus.search_complete  = 1'b0;
        bus.setting_complete = 1'b0;
        checkOutput("rsp_arrival", KWID'(rspK >= 0), KWID'(1));
        if (rspK < 0) return;
        checkOutput("strobe_edge", KWID'(strobeK), KWID'(KWID));
        checkOutput("search_pulses", KWID'(nSearch), KWID'(op ? 0 : 1));
        checkOutput("setting_pulses", KWID'(nSetting), KWID'(op ? 1 : 0));
        checkOutput("rsp_latency", KWID'(rspK), KWID'(expLat));
        checkOutput("rsp_fields", KWID'({bus.rsp_op, bus.rsp_timeout, bus.rsp_mismatch, bus.rsp_ruleid}),
                    KWID'({op, exp}));
        checkOutput("resp_idle_lines", KWID'({bus.cmd_ready, bus.key, bus.setting_id, bus.setting_maskid,
                                              bus.setting_priority, bus.search, bus.setting}), '0);
        for (int h = 0; h < holdCycles; h++) begin
            bus.cmd_valid = 1'b1;
            randomCmdFields();
            @(negedge clk);
            checkOutput("rsp_hold", KWID'({bus.rsp_valid, bus.rsp_op, bus.rsp_timeout, bus.rsp_mismatch,
                                            bus.rsp_ruleid, bus.cmd_ready}),
                        KWID'({1'b1, op, exp, 1'b0}));
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_release", KWID'({bus.rsp_valid, bus.cmd_ready}), KWID'(2'b01));
    endtask

    task automatic applyResetMidShift();
        bit ok;
        int strays;
        logic [KWID-1:0] key;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        acceptCommand(1'b0, key, IDWID'($urandom()), MASKWID'($urandom()), IDWID'($urandom()), ok);
        if (!ok) return;
        repeat (50) @(negedge clk);
        checkOutput("shift50_key", KWID'(bus.key), KWID'(key[KWID-1-50]));
        rstN = 1'b0;
        #1;
        checkAllZero("reset_mid_shift");
        repeat (2) @(negedge clk);
        checkAllZero("reset_mid_shift_held");
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_abort", KWID'(bus.cmd_ready), KWID'(1));
        strays = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.search || bus.setting || bus.rsp_valid) strays++;
            @(negedge clk);
        end
        checkOutput("no_strobe_after_abort", KWID'(strays), '0);
    endtask

    initial begin
        logic op;
        bus.cmd_valid        = 1'b0;
        bus.search_complete  = 1'b0;
        bus.setting_complete = 1'b0;
        bus.ruleid           = '0;
        bus.mismatch         = 1'b0;
        bus.rsp_ready        = 1'b0;
        randomCmdFields();
        #1 rstN = 1'b0;
        #1 checkAllZero("reset_async");
        repeat (3) @(negedge clk);
        checkAllZero("reset_held");
        rstN = 1'b1;
        #1 checkOutput("ready_before_clock", KWID'(bus.cmd_ready), '0);
        @(negedge clk);
        checkOutput("ready_first_clock", KWID'(bus.cmd_ready), KWID'(1));

        $display("[TB] directed setting");
        applyStimulus(1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h00A5, 18'h2_0001,
                      16'h0007, 3, 16'hBEEF, 1'b1, 1'b0, 0);
        $display("[TB] directed search, minimum latency");
        applyStimulus(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h1111, 18'h3_FFFF,
                      16'hFFFF, 1, 16'h1234, 1'b0, 1'b0, 0);
        $display("[TB] search timeout and late completion");
        applyStimulus(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0001, 18'h0,
                      16'h8000, 0, 16'hAAAA, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0002, 18'h1,
                      16'h0, TIMEOUT, 16'h5A5A, 1'b1, 1'b0, 0);
        $display("[TB] search with stray setting completion, then response hold");
        applyStimulus(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0003, 18'h2,
                      16'h1, 4, 16'hC3C3, 1'b1, 1'b1, 0);
        applyStimulus(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0004, 18'h3,
                      16'h2, 2, 16'h7E57, 1'b0, 1'b0, 20);
        $display("[TB] reset mid-shift");
        applyResetMidShift();
        applyStimulus(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0005, 18'h4,
                      16'h3, 5, 16'h0BAD, 1'b1, 1'b0, 0);

        $display("[TB] randomised commands");
        for (int n = 0; n < 8; n++) begin
            op = 1'($urandom_range(0, 1));
            applyStimulus(op, {$urandom(), $urandom(), $urandom(), $urandom()}, IDWID'($urandom()),
                          MASKWID'($urandom()), IDWID'($urandom()), int'($urandom_range(0, TIMEOUT + 2)),
                          IDWID'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
